// File: rtl/jtdd_sdram_sched_if.sv
// SDRAM controller request bus between the access scheduler
// and the SDRAM controller.
interface jtdd_sdram_sched_if #(
  parameter int AW = 22
) ();
  logic          sdram_req;
  logic          sdram_we;
  logic [AW-1:0] sdram_addr;
  logic [15:0]   sdram_din;
  logic [1:0]    sdram_mask;
  logic          sdram_ack;
  logic          sdram_rdy;
  logic [15:0]   sdram_dout;

  modport master (
    output sdram_req, sdram_we, sdram_addr,
    output sdram_din, sdram_mask,
    input  sdram_ack, sdram_rdy, sdram_dout
  );

  modport slave (
    input  sdram_req, sdram_we, sdram_addr,
    input  sdram_din, sdram_mask,
    output sdram_ack, sdram_rdy, sdram_dout
  );
endinterface

// File: rtl/jtdd_sdram_sched.sv
// SDRAM access scheduler: buffered ROM download writes have
// priority, CPU/graphics reads share the rest round-robin.
module jtdd_sdram_sched #(
  parameter int AW         = 22,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            downloading,
  input  logic [AW-1:0]   prog_addr,
  input  logic [7:0]      prog_data,
  input  logic [1:0]      prog_mask,
  input  logic            prog_we,
  output logic            prog_rdy,
  output logic            prog_ovf,
  input  logic [2:0]      rd_req,
  input  logic [3*AW-1:0] rd_addr,
  output logic [2:0]      rd_ok,
  output logic [15:0]     rd_data,
  jtdd_sdram_sched_if.master sdram
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
    logic [1:0]    mask;
  } ent_t;

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  state_t        state_q, state_d;
  ent_t          mem_q [FIFO_DEPTH];
  ent_t          head;
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic [1:0]    ptr_q, ptr_d, grant_q, grant_d, win;
  logic          ack_q, ack_d;
  logic          req_q, req_d, we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   din_q, din_d;
  logic [1:0]    mask_q, mask_d;
  logic          prdy_q, prdy_d, ovf_q, ovf_d;
  logic [2:0]    ok_q, ok_d;
  logic [15:0]   data_q, data_d;
  logic          full, empty, done, push, pop;

  assign full  = cnt_q == (PW+1)'(FIFO_DEPTH);
  assign empty = cnt_q == '0;
  assign head  = mem_q[rp_q];

  // rdy only counts once the controller has acknowledged the request
  assign done = (state_q != IDLE) && sdram.sdram_rdy &&
                (ack_q || (req_q && sdram.sdram_ack));
  assign pop  = (state_q == WR) && done;
  assign push = prog_we && (!full || pop);

  assign sdram.sdram_req  = req_q;
  assign sdram.sdram_we   = we_q;
  assign sdram.sdram_addr = addr_q;
  assign sdram.sdram_din  = din_q;
  assign sdram.sdram_mask = mask_q;
  assign prog_rdy = prdy_q;
  assign prog_ovf = ovf_q;
  assign rd_ok    = ok_q;
  assign rd_data  = data_q;

  // round-robin pick: first set request at or after ptr
  always_comb begin
    logic [1:0] idx;
    idx = '0;
    win = ptr_q;
    for (int i = 2; i >= 0; i--) begin
      idx = 2'((int'(ptr_q) + i) % 3);
      if (rd_req[idx]) win = idx;
    end
  end

  // download write buffer storage
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= '{prog_addr, prog_data, prog_mask};
  end

  // next state, access launch and completion
  always_comb begin
    state_d = state_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    cnt_d   = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    ptr_d   = ptr_q;
    grant_d = grant_q;
    ack_d   = ack_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    din_d   = din_q;
    mask_d  = mask_q;
    prdy_d  = 1'b0;
    ovf_d   = ovf_q | (prog_we & full & ~pop);
    ok_d    = 3'b000;
    data_d  = data_q;
    if (push) wp_d = wp_q + 1'b1;
    if (pop)  rp_d = rp_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d = WR;
          req_d   = 1'b1;
          we_d    = 1'b1;
          ack_d   = 1'b0;
          addr_d  = head.addr;
          din_d   = {head.data, head.data};
          mask_d  = head.mask;
        end else if (!downloading && rd_req != 3'b000) begin
          state_d = RD;
          req_d   = 1'b1;
          we_d    = 1'b0;
          ack_d   = 1'b0;
          grant_d = win;
          addr_d  = rd_addr[int'(win)*AW +: AW];
        end
      end
      WR, RD: begin
        if (req_q && sdram.sdram_ack) begin
          req_d = 1'b0;
          ack_d = 1'b1;
        end
        if (done) begin
          state_d = IDLE;
          req_d   = 1'b0;
          if (state_q == WR) begin
            prdy_d = 1'b1;
          end else begin
            data_d = sdram.sdram_dout;
            ok_d   = 3'b001 << grant_q;
            ptr_d  = (grant_q == 2'd2) ? 2'd0 : grant_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      ack_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      mask_q  <= 2'b11;
      prdy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ok_q    <= 3'b000;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      mask_q  <= mask_d;
      prdy_q  <= prdy_d;
      ovf_q   <= ovf_d;
      ok_q    <= ok_d;
      data_q  <= data_d;
    end
  end
endmodule
